// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the execute stage and alu_seq.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_cout;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_cout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_cout
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle sequencer running 32-bit add/sub/logic/neg and 16x16 multiply
// on an external combinational 16-bit ALU.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  output logic [15:0] alu_x_o,
  output logic [15:0] alu_y_o,
  output logic        alu_zx_o,
  output logic        alu_nx_o,
  output logic        alu_zy_o,
  output logic        alu_ny_o,
  output logic        alu_f0_o,
  output logic        alu_f1_o,
  output logic        alu_no_o,
  output logic        alu_cin_o,
  input  logic [15:0] alu_out_i,
  input  logic        alu_cout_i
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_NEG, OP_PASS
  } op_t;

  state_t      state_q;
  op_t         op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        carry_q;
  logic [3:0]  cnt_q;
  logic        is_arith;

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_NEG);

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = res_q;
  assign bus.rsp_cout  = carry_q;

  always_comb begin
    alu_x_o   = '0;
    alu_y_o   = '0;
    alu_zx_o  = 1'b0;
    alu_nx_o  = 1'b0;
    alu_zy_o  = 1'b0;
    alu_ny_o  = 1'b0;
    alu_f0_o  = 1'b0;
    alu_f1_o  = 1'b0;
    alu_no_o  = 1'b0;
    alu_cin_o = 1'b0;
    case (state_q)
      S_LO, S_HI: begin
        alu_x_o = (state_q == S_LO) ? a_q[15:0] : a_q[31:16];
        alu_y_o = (state_q == S_LO) ? b_q[15:0] : b_q[31:16];
        case (op_q)
          OP_ADD: ;
          OP_SUB: alu_ny_o = 1'b1;
          OP_AND: alu_f1_o = 1'b1;
          OP_OR:  alu_f0_o = 1'b1;
          OP_XOR: begin
            alu_f1_o = 1'b1;
            alu_f0_o = 1'b1;
          end
          OP_NEG: begin
            alu_nx_o = 1'b1;
            alu_zy_o = 1'b1;
          end
          default: alu_zy_o = 1'b1;
        endcase
        if (state_q == S_LO) alu_cin_o = (op_q == OP_SUB) || (op_q == OP_NEG);
        else                 alu_cin_o = is_arith & carry_q;
      end
      S_MUL: begin
        // res_q doubles as {acc_hi, acc_lo} while multiplying
        alu_x_o  = res_q[31:16];
        alu_y_o  = a_q[15:0];
        alu_zy_o = ~res_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= op_t'(bus.req_op);
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            if (op_t'(bus.req_op) == OP_MUL) begin
              res_q   <= {16'h0000, bus.req_b[15:0]};
              state_q <= S_MUL;
            end else begin
              state_q <= S_LO;
            end
          end
        end
        S_LO: begin
          res_q[15:0] <= alu_out_i;
          carry_q     <= alu_cout_i;
          state_q     <= S_HI;
        end
        S_HI: begin
          res_q[31:16] <= alu_out_i;
          carry_q      <= is_arith & alu_cout_i;
          state_q      <= S_DONE;
        end
        S_MUL: begin
          res_q <= {alu_cout_i, alu_out_i, res_q[15:1]};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            carry_q <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
